// File: rtl/ddrphy_dly_pkg.sv
// rtl/ddrphy_dly_pkg.sv - state encoding and timing constants for the lane delay-line sequencer
package ddrphy_dly_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 16;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_LEAD  = 3'd1;
    localparam logic [STATE_W-1:0] S_PULSE = 3'd2;
    localparam logic [STATE_W-1:0] S_GAP   = 3'd3;
    localparam logic [STATE_W-1:0] S_TRAIL = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

    // A phase of N cycles is timed by loading N-1 and leaving when the counter reads zero.
    function automatic logic [CNT_W-1:0] cyc_to_cnt(input int cycles);
        return (cycles > 1) ? CNT_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/ddrphy_dly_cnt.sv
// rtl/ddrphy_dly_cnt.sv - loadable down-counter with zero flag, times the LEAD, GAP and TRAIL phases
module ddrphy_dly_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ddrphy_lane_dly_seq.sv
// rtl/ddrphy_lane_dly_seq.sv - per-lane delay-line MOVE/LOAD sequencer with clock-pause bracketing
// Optional per-lane tap tracking is built when DDRPHY_DLY_TAP_TRACK_EN is defined.
module ddrphy_lane_dly_seq
    import ddrphy_dly_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    parameter int STEP_W      = 8,
    parameter int PAUSE_LEAD  = 2,
    parameter int PAUSE_TRAIL = 2,
    parameter int MOVE_GAP    = 3,
    parameter int TAP_W       = 8
) (
    input  logic                 FAB_CLK,
    input  logic                 RESET_N,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [LANE_W-1:0]    REQ_LANE,
    input  logic                 REQ_TX,
    input  logic                 REQ_DIR,
    input  logic                 REQ_LOAD,
    input  logic [STEP_W-1:0]    REQ_STEPS,
    output logic                 DONE_VALID,
    output logic                 DONE_OOR,
    output logic [STEP_W-1:0]    DONE_STEPS,
    output logic [TAP_W-1:0]     DONE_TAP_POS,
    output logic                 BUSY,
    input  logic [NUM_LANES-1:0] RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic [NUM_LANES-1:0] TX_DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0] DELAY_LINE_SEL,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE
);

    logic [STATE_W-1:0] state_q,  state_d;
    logic [LANE_W-1:0]  lane_q,   lane_d;
    logic               tx_q,     tx_d;
    logic               dir_q,    dir_d;
    logic               load_q,   load_d;
    logic [STEP_W-1:0]  steps_q,  steps_d;
    logic [STEP_W-1:0]  issued_q, issued_d;
    logic               oor_q,    oor_d;
    logic               quiet_q,  quiet_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               lane_ok;
    logic               zero_req;
    logic               line_oor;
    logic               active;
    logic [NUM_LANES-1:0] lane_dec;

    ddrphy_dly_cnt #(.W(CNT_W)) u_cnt (
        .clk      (FAB_CLK),
        .rst_n    (RESET_N),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // An out-of-range lane index decodes to no lane at all.
    always_comb begin
        lane_dec = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_dec[i] = (lane_q == LANE_W'(i));
        end
    end

    assign line_oor = |((tx_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE) & lane_dec);
    assign lane_ok  = (int'(REQ_LANE) < NUM_LANES);
    assign zero_req = !REQ_LOAD && (REQ_STEPS == '0);

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        tx_d     = tx_q;
        dir_d    = dir_q;
        load_d   = load_q;
        steps_d  = steps_q;
        issued_d = issued_q;
        oor_d    = oor_q;
        quiet_d  = quiet_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    lane_d   = REQ_LANE;
                    tx_d     = REQ_TX;
                    dir_d    = REQ_DIR;
                    load_d   = REQ_LOAD;
                    steps_d  = REQ_STEPS;
                    issued_d = '0;
                    oor_d    = !lane_ok;
                    quiet_d  = !lane_ok || zero_req;
                    cnt_load = 1'b1;
                    // Quiet requests spend one unpaused cycle in TRAIL so DONE lands two cycles out.
                    if (!lane_ok || zero_req) begin
                        state_d = S_TRAIL;
                        cnt_val = '0;
                    end else begin
                        state_d = S_LEAD;
                        cnt_val = cyc_to_cnt(PAUSE_LEAD);
                    end
                end
            end
            S_LEAD: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                state_d  = S_GAP;
                cnt_load = 1'b1;
                cnt_val  = cyc_to_cnt(MOVE_GAP);
                if (!load_q) begin
                    issued_d = issued_q + STEP_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = cyc_to_cnt(PAUSE_TRAIL);
                    if (line_oor) begin
                        oor_d   = 1'b1;
                        state_d = S_TRAIL;
                    end else if (load_q || (issued_q == steps_q)) begin
                        state_d = S_TRAIL;
                    end else begin
                        cnt_load = 1'b0;
                        state_d  = S_PULSE;
                    end
                end
            end
            S_TRAIL: begin
                if (cnt_zero) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            tx_q     <= 1'b0;
            dir_q    <= 1'b0;
            load_q   <= 1'b0;
            steps_q  <= '0;
            issued_q <= '0;
            oor_q    <= 1'b0;
            quiet_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            tx_q     <= tx_d;
            dir_q    <= dir_d;
            load_q   <= load_d;
            steps_q  <= steps_d;
            issued_q <= issued_d;
            oor_q    <= oor_d;
            quiet_q  <= quiet_d;
        end
    end

    assign active = !quiet_q && ((state_q == S_LEAD) || (state_q == S_PULSE) ||
                                 (state_q == S_GAP)  || (state_q == S_TRAIL));

    assign REQ_READY            = (state_q == S_IDLE);
    assign BUSY                 = !REQ_READY;
    assign HS_IO_CLK_PAUSE      = active ? lane_dec : '0;
    assign DELAY_LINE_SEL       = (active && tx_q)  ? lane_dec : '0;
    assign DELAY_LINE_DIRECTION = (active && dir_q) ? lane_dec : '0;
    assign DELAY_LINE_MOVE      = ((state_q == S_PULSE) && !load_q) ? lane_dec : '0;
    assign DELAY_LINE_LOAD      = ((state_q == S_PULSE) &&  load_q) ? lane_dec : '0;
    assign DONE_VALID           = (state_q == S_DONE);
    assign DONE_OOR             = DONE_VALID && oor_q;
    assign DONE_STEPS           = DONE_VALID ? issued_q : '0;

`ifdef DDRPHY_DLY_TAP_TRACK_EN
    logic [TAP_W-1:0] tap_q [NUM_LANES][2];
    logic [TAP_W-1:0] tap_d [NUM_LANES][2];
    logic [TAP_W-1:0] tap_sel;

    // Index [lane][line] with line 1 = TX; MOVE saturates at both ends of the counter.
    always_comb begin
        tap_d   = tap_q;
        tap_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (lane_dec[i] && (tx_q == 1'(j))) begin
                    tap_sel = tap_q[i][j];
                    if (state_q == S_PULSE) begin
                        if (load_q) begin
                            tap_d[i][j] = '0;
                        end else if (dir_q && (tap_q[i][j] != '1)) begin
                            tap_d[i][j] = tap_q[i][j] + TAP_W'(1);
                        end else if (!dir_q && (tap_q[i][j] != '0)) begin
                            tap_d[i][j] = tap_q[i][j] - TAP_W'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                for (int j = 0; j < 2; j++) begin
                    tap_q[i][j] <= '0;
                end
            end
        end else begin
            tap_q <= tap_d;
        end
    end

    assign DONE_TAP_POS = DONE_VALID ? tap_sel : '0;
`else
    assign DONE_TAP_POS = '0;
`endif

endmodule

// File: tb/tb_ddrphy_lane_dly_seq.sv
// tb/tb_ddrphy_lane_dly_seq.sv - directed self-checking bench for ddrphy_lane_dly_seq
module tb_ddrphy_lane_dly_seq;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_ready, req_tx, req_dir, req_load;
    logic [1:0] req_lane;
    logic [7:0] req_steps;
    logic       done_valid, done_oor, busy;
    logic [7:0] done_steps, done_tap;
    logic [3:0] rx_oor, tx_oor, sel, dir, move, load, pause;

    logic       r3_valid, r3_ready, r3_done, r3_oor, r3_busy;
    logic [1:0] r3_lane;
    logic [7:0] r3_steps_o, r3_tap;
    logic [2:0] r3_sel, r3_dir, r3_move, r3_load, r3_pause;

    int passed = 0;
    int total  = 0;

    logic [21:0] exp_v;
    logic [3:0]  exp_p, exp_m;
    logic [7:0]  got_steps, got_tap;
    logic        got_oor;
    int          pulses, dones;

    ddrphy_lane_dly_seq u_dut (
        .FAB_CLK(clk), .RESET_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_LANE(req_lane),
        .REQ_TX(req_tx), .REQ_DIR(req_dir), .REQ_LOAD(req_load), .REQ_STEPS(req_steps),
        .DONE_VALID(done_valid), .DONE_OOR(done_oor), .DONE_STEPS(done_steps),
        .DONE_TAP_POS(done_tap), .BUSY(busy),
        .RX_DELAY_LINE_OUT_OF_RANGE(rx_oor), .TX_DELAY_LINE_OUT_OF_RANGE(tx_oor),
        .DELAY_LINE_SEL(sel), .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_MOVE(move),
        .DELAY_LINE_LOAD(load), .HS_IO_CLK_PAUSE(pause)
    );

    ddrphy_lane_dly_seq #(.NUM_LANES(3)) u_dut3 (
        .FAB_CLK(clk), .RESET_N(rst_n),
        .REQ_VALID(r3_valid), .REQ_READY(r3_ready), .REQ_LANE(r3_lane),
        .REQ_TX(1'b0), .REQ_DIR(1'b1), .REQ_LOAD(1'b0), .REQ_STEPS(8'd4),
        .DONE_VALID(r3_done), .DONE_OOR(r3_oor), .DONE_STEPS(r3_steps_o),
        .DONE_TAP_POS(r3_tap), .BUSY(r3_busy),
        .RX_DELAY_LINE_OUT_OF_RANGE(3'b000), .TX_DELAY_LINE_OUT_OF_RANGE(3'b000),
        .DELAY_LINE_SEL(r3_sel), .DELAY_LINE_DIRECTION(r3_dir), .DELAY_LINE_MOVE(r3_move),
        .DELAY_LINE_LOAD(r3_load), .HS_IO_CLK_PAUSE(r3_pause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic issue(input logic [1:0] lane, input logic tx, input logic d,
                         input logic ld, input logic [7:0] steps);
        req_lane  = lane;
        req_tx    = tx;
        req_dir   = d;
        req_load  = ld;
        req_steps = steps;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic [1:0] lane, input logic tx,
                           input logic d, input logic ld, input logic [7:0] steps,
                           output logic [7:0] steps_o, output logic oor_o, output logic [7:0] tap_o);
        int n;
        issue(lane, tx, d, ld, steps);
        n = 0;
        while (!done_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " done_seen"}, done_valid, 1);
        steps_o = done_steps;
        oor_o   = done_oor;
        tap_o   = done_tap;
        tick();
    endtask

    // Vector order: {pause, move, load, sel, dir, done_valid, req_ready}
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_lane = '0; req_tx = 1'b0; req_dir = 1'b0;
        req_load = 1'b0; req_steps = '0; rx_oor = '0; tx_oor = '0;
        r3_valid = 1'b0; r3_lane = '0;
        #2;
        chk("reset_vec", {pause, move, load, sel, dir, done_valid, req_ready}, 22'h1);
        chk("reset_busy", {busy, done_oor, done_steps, done_tap}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // RX step: lane2, DIR=1, 3 steps
        issue(2'd2, 1'b0, 1'b1, 1'b0, 8'd3);
        for (int c = 1; c <= 18; c++) begin
            exp_p = (c <= 16) ? 4'b0100 : 4'b0000;
            exp_m = (c == 3 || c == 7 || c == 11) ? 4'b0100 : 4'b0000;
            exp_v = {exp_p, exp_m, 4'b0000, 4'b0000, exp_p, (c == 17), (c == 18)};
            chk($sformatf("rx_step c%0d", c), {pause, move, load, sel, dir, done_valid, req_ready}, exp_v);
            if (c == 17) begin
                chk("rx_step steps", done_steps, 3);
                chk("rx_step oor", done_oor, 0);
`ifdef DDRPHY_DLY_TAP_TRACK_EN
                chk("rx_step tap", done_tap, 3);
`else
                chk("rx_step tap", done_tap, 0);
`endif
            end
            if (c < 18) tick();
        end

        // Load: lane1, TX, steps field ignored
        issue(2'd1, 1'b1, 1'b0, 1'b1, 8'd7);
        for (int c = 1; c <= 10; c++) begin
            exp_p = (c <= 8) ? 4'b0010 : 4'b0000;
            exp_m = (c == 3) ? 4'b0010 : 4'b0000;
            exp_v = {exp_p, 4'b0000, exp_m, exp_p, 4'b0000, (c == 9), (c == 10)};
            chk($sformatf("load c%0d", c), {pause, move, load, sel, dir, done_valid, req_ready}, exp_v);
            if (c == 9) chk("load steps_oor", {done_oor, done_steps}, 0);
            if (c < 10) tick();
        end

        // Out of range: lane0 RX, 10 steps, RX_OOR[0] rises after 4th pulse; TX_OOR must be ignored
        tx_oor = 4'b1111;
        pulses = 0;
        issue(2'd0, 1'b0, 1'b0, 1'b0, 8'd10);
        for (int c = 1; c <= 22; c++) begin
            if (c == 16) rx_oor = 4'b0001;
            if (move == 4'b0001) pulses++;
            if (c == 21) begin
                chk("oor done", done_valid, 1);
                chk("oor flag", done_oor, 1);
                chk("oor steps", done_steps, 4);
            end
            if (c < 22) tick();
        end
        chk("oor pulse_count", pulses, 4);
        chk("oor ready", req_ready, 1);
        rx_oor = '0;
        tx_oor = 4'b1000;

        // OOR already high at acceptance: one pulse issued, then abort
        run_req("pre_oor", 2'd3, 1'b1, 1'b1, 1'b0, 8'd5, got_steps, got_oor, got_tap);
        chk("pre_oor result", {got_oor, got_steps}, {1'b1, 8'd1});
        tx_oor = '0;

        // Zero steps: no pause, DONE two cycles after acceptance
        issue(2'd3, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("zero c1", {pause, move, load, sel, dir, done_valid, req_ready}, 22'h0);
        tick();
        chk("zero c2", {pause, done_valid, done_oor, done_steps}, {4'b0000, 1'b1, 1'b0, 8'd0});
        tick();
        chk("zero c3 ready", req_ready, 1);

        // Invalid lane on a 3-lane instance
        r3_lane = 2'd3;
        r3_valid = 1'b1;
        tick();
        r3_valid = 1'b0;
        chk("badlane c1", {r3_pause, r3_move, r3_done, r3_ready}, 0);
        tick();
        chk("badlane c2", {r3_pause, r3_done, r3_oor, r3_steps_o}, {3'b000, 1'b1, 1'b1, 8'd0});
        tick();
        chk("badlane ready", r3_ready, 1);

        // Reset during the second GAP
        issue(2'd2, 1'b1, 1'b1, 1'b0, 8'd3);
        for (int c = 1; c < 9; c++) tick();
        chk("mid pre", {pause, sel}, {4'b0100, 4'b0100});
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid reset_vec", {pause, move, load, sel, dir, done_valid, req_ready}, 22'h1);
        tick(); tick();
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done_valid) dones++;
        end
        chk("mid no_done", dones, 0);
        chk("mid ready", req_ready, 1);

`ifdef DDRPHY_DLY_TAP_TRACK_EN
        run_req("tap_load", 2'd1, 1'b0, 1'b0, 1'b1, 8'd0, got_steps, got_oor, got_tap);
        chk("tap after load", got_tap, 0);
        run_req("tap_up", 2'd1, 1'b0, 1'b1, 1'b0, 8'd5, got_steps, got_oor, got_tap);
        chk("tap after +5", got_tap, 5);
        run_req("tap_down", 2'd1, 1'b0, 1'b0, 1'b0, 8'd7, got_steps, got_oor, got_tap);
        chk("tap after -7", got_tap, 0);
        chk("tap down steps", got_steps, 7);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
